irq_request_ctrl: RTL

Upstream interrupt front-end for `core_top`, driving the core's single `interrupt` input. It synchronises asynchronous external request lines, latches rising edges as pending requests and arbitrates them by fixed priority. It issues one-cycle interrupt pulses to the core only while the program sequencer reports idle, then waits for an acknowledge with a timeout and enforces a hold-off gap between pulses.

---
 rtl/irq_request_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/irq_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_request_ctrl
// Purpose  : Interrupt front-end for core_top. Synchronises asynchronous
//            request lines, latches rising edges as pending requests,
//            arbitrates them by fixed priority (line 0 highest) and issues
//            one-cycle interrupt pulses while the sequencer is idle. Each
//            pulse waits for an acknowledge (with timeout) and is followed
//            by a hold-off gap.
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous active-low reset
//            irq_in       - asynchronous request lines (rising-edge events)
//            irq_mask     - 1 = line excluded from arbitration
//            ps_idle      - program sequencer idle flag
//            irq_ack      - core accepted the issued interrupt
//            sticky_clr   - clears irq_overrun and ack_timeout
//            interrupt    - registered one-cycle pulse to the core
//            irq_id       - index of the request being serviced
//            irq_pending  - pending request vector
//            irq_overrun  - sticky: edge on an already-pending line
//            ack_timeout  - sticky: acknowledge never arrived
// Revision : 1.0 - initial release
// ============================================================================
module irq_request_ctrl #(
  parameter int IRQ_LINES   = 4,
  parameter int ID_WIDTH    = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter int HOLDOFF     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IRQ_LINES-1:0] irq_in,
  input  logic [IRQ_LINES-1:0] irq_mask,
  input  logic                 ps_idle,
  input  logic                 irq_ack,
  input  logic                 sticky_clr,
  output logic                 interrupt,
  output logic [ID_WIDTH-1:0]  irq_id,
  output logic [IRQ_LINES-1:0] irq_pending,
  output logic                 irq_overrun,
  output logic                 ack_timeout
);

  // Counter widths; a width of at least 1 keeps HOLDOFF == 1 legal.
  localparam int C_TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int C_HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(ACK_TIMEOUT - 1);
  localparam logic [C_HO_W-1:0] C_HO_LOAD = C_HO_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [IRQ_LINES-1:0] r_sync1;
  logic [IRQ_LINES-1:0] r_sync2;
  logic [IRQ_LINES-1:0] r_prev;
  logic [IRQ_LINES-1:0] r_pending;
  logic [C_TO_W-1:0]    r_to_cnt;
  logic [C_HO_W-1:0]    r_ho_cnt;
  logic [ID_WIDTH-1:0]  r_irq_id;
  logic                 r_interrupt;
  logic                 r_overrun;
  logic                 r_ack_timeout;

  logic [IRQ_LINES-1:0] w_edge;
  logic [IRQ_LINES-1:0] w_eligible;
  logic [IRQ_LINES-1:0] w_clr;
  logic [ID_WIDTH-1:0]  w_winner;
  logic                 w_any_eligible;
  logic                 w_ack_accept;
  logic                 w_to_expire;
  logic [C_TO_W-1:0]    w_to_cnt_nxt;
  logic [C_HO_W-1:0]    w_ho_cnt_nxt;
  logic                 w_any_overrun;

  assign w_edge     = r_sync2 & ~r_prev;
  assign w_eligible = r_pending & ~irq_mask;

  // Fixed-priority pick: scanning downwards leaves the lowest set index.
  always_comb begin
    w_winner       = '0;
    w_any_eligible = 1'b0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner       = ID_WIDTH'(i);
        w_any_eligible = 1'b1;
      end
    end
  end

  // Clear mask for the serviced line; a simultaneous edge re-sets the bit
  // and is not an overrun because the old request has just been retired.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < IRQ_LINES; i++) begin
      w_clr[i] = w_ack_accept && (r_irq_id == ID_WIDTH'(i));
    end
  end

  assign w_any_overrun = |(w_edge & r_pending & ~w_clr);

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_to_cnt_nxt = '0;
    w_ho_cnt_nxt = '0;
    w_ack_accept = 1'b0;
    w_to_expire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_eligible && ps_idle) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (irq_ack) begin
          w_ack_accept = 1'b1;
          w_ho_cnt_nxt = C_HO_LOAD;
          w_state_nxt  = S_HOLDOFF;
        end else if (r_to_cnt == C_TO_LAST) begin
          w_to_expire = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (r_ho_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ho_cnt_nxt = r_ho_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_prev        <= '0;
      r_pending     <= '0;
      r_to_cnt      <= '0;
      r_ho_cnt      <= '0;
      r_irq_id      <= '0;
      r_interrupt   <= 1'b0;
      r_overrun     <= 1'b0;
      r_ack_timeout <= 1'b0;
    end else begin
      r_sync1   <= irq_in;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_to_cnt  <= w_to_cnt_nxt;
      r_ho_cnt  <= w_ho_cnt_nxt;
      // The pulse register is loaded on the same edge that enters ISSUE,
      // so interrupt is high exactly while the FSM sits in ISSUE.
      r_interrupt <= (w_state_nxt == S_ISSUE);
      if (r_state == S_IDLE && w_state_nxt == S_ISSUE) begin
        r_irq_id <= w_winner;
      end
      r_overrun     <= (r_overrun & ~sticky_clr) | w_any_overrun;
      r_ack_timeout <= (r_ack_timeout & ~sticky_clr) | w_to_expire;
    end
  end

  assign interrupt   = r_interrupt;
  assign irq_id      = r_irq_id;
  assign irq_pending = r_pending;
  assign irq_overrun = r_overrun;
  assign ack_timeout = r_ack_timeout;

endmodule
`default_nettype wire
